// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the time-of-day set controller.
//   mode_e  : display/edit mode encoding (RUN, SET_HR, SET_MIN)
//   hms_t   : packed hours/minutes/seconds payload
//   wrap_inc: increment-with-wrap helper used by every time field
package time_set_ctrl_pkg;

    localparam int unsigned HR_W        = 5;
    localparam int unsigned MS_W        = 6;
    localparam int unsigned MAX_HR      = 23;
    localparam int unsigned MAX_MIN_SEC = 59;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_e;

    typedef struct packed {
        logic [HR_W-1:0] hr;
        logic [MS_W-1:0] mn;
        logic [MS_W-1:0] sc;
    } hms_t;

    // Returns v+1, or 0 once v has reached max.
    function automatic logic [MS_W-1:0] wrap_inc(input logic [MS_W-1:0] v,
                                                 input logic [MS_W-1:0] max);
        return (v >= max) ? '0 : v + MS_W'(1);
    endfunction

endpackage

// File: rtl/time_set_ctrl_tick_prescaler.sv
// Divides clk down to a one-per-second strobe.
//   clk  : system clock
//   rst  : async active-high reset, count returns to 0
//   clr  : synchronous restart of the count from 0
//   tick : high while the count sits at TICKS_PER_SEC-1 (consumer registers it)
module tick_prescaler #(
    parameter int unsigned TICKS_PER_SEC = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: wrap after the last value or on an explicit restart.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Clock time keeper with a two-button set interface.
//   clk, rst         : system clock, async active-high reset
//   btn_mode         : one-cycle pulse, cycles RUN -> SET_HR -> SET_MIN -> RUN
//   btn_inc          : one-cycle pulse, increments the field being set
//   hours/minutes/seconds : current time of day
//   mode             : current mode (mode_e encoding)
//   sec_tick         : one-cycle pulse per second
//   blink            : blink enable for the field being set
//   day_tick         : one-cycle pulse on the midnight rollover
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_mode,
    input  logic            btn_inc,
    output logic [HR_W-1:0] hours,
    output logic [MS_W-1:0] minutes,
    output logic [MS_W-1:0] seconds,
    output logic [1:0]      mode,
    output logic            sec_tick,
    output logic            blink,
    output logic            day_tick
);

    mode_e mode_q, mode_d;
    hms_t  time_q, time_d;
    logic  blink_q, blink_d;
    logic  sec_tick_q, sec_tick_d;
    logic  day_tick_q, day_tick_d;

    logic  presc_tick_c;
    logic  presc_clr_c;
    logic  at_midnight_c;

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .clr (presc_clr_c),
        .tick(presc_tick_c)
    );

    assign at_midnight_c = (time_q.hr == HR_W'(MAX_HR))
                        && (time_q.mn == MS_W'(MAX_MIN_SEC))
                        && (time_q.sc == MS_W'(MAX_MIN_SEC));

    // Next-state and output logic; btn_mode always wins over btn_inc and ticks.
    always_comb begin
        mode_d      = mode_q;
        time_d      = time_q;
        blink_d     = blink_q;
        day_tick_d  = 1'b0;
        presc_clr_c = 1'b0;

        unique case (mode_q)
            RUN: begin
                blink_d = 1'b0;
                if (btn_mode) begin
                    mode_d      = SET_HR;
                    time_d.sc   = '0;
                    presc_clr_c = 1'b1;
                    blink_d     = 1'b1;
                end else if (presc_tick_c) begin
                    time_d.sc = wrap_inc(time_q.sc, MS_W'(MAX_MIN_SEC));
                    if (time_q.sc == MS_W'(MAX_MIN_SEC)) begin
                        time_d.mn = wrap_inc(time_q.mn, MS_W'(MAX_MIN_SEC));
                        if (time_q.mn == MS_W'(MAX_MIN_SEC)) begin
                            time_d.hr = HR_W'(wrap_inc(MS_W'(time_q.hr), MS_W'(MAX_HR)));
                        end
                    end
                    day_tick_d = at_midnight_c;
                end
            end
            SET_HR: begin
                if (btn_mode) begin
                    mode_d  = SET_MIN;
                    blink_d = 1'b1;
                end else begin
                    if (btn_inc) begin
                        time_d.hr = HR_W'(wrap_inc(MS_W'(time_q.hr), MS_W'(MAX_HR)));
                    end
                    if (presc_tick_c) begin
                        blink_d = ~blink_q;
                    end
                end
            end
            SET_MIN: begin
                if (btn_mode) begin
                    // Restart the second so RUN resumes on a full-second boundary.
                    mode_d      = RUN;
                    blink_d     = 1'b0;
                    presc_clr_c = 1'b1;
                end else begin
                    if (btn_inc) begin
                        time_d.mn = wrap_inc(time_q.mn, MS_W'(MAX_MIN_SEC));
                    end
                    if (presc_tick_c) begin
                        blink_d = ~blink_q;
                    end
                end
            end
            default: begin
                mode_d  = RUN;
                blink_d = 1'b0;
            end
        endcase

        // A tick coinciding with a prescaler restart is dropped.
        sec_tick_d = presc_tick_c && !presc_clr_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= RUN;
            time_q     <= '0;
            blink_q    <= 1'b0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            time_q     <= time_d;
            blink_q    <= blink_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
        end
    end

    assign hours    = time_q.hr;
    assign minutes  = time_q.mn;
    assign seconds  = time_q.sc;
    assign mode     = mode_q;
    assign sec_tick = sec_tick_q;
    assign blink    = blink_q;
    assign day_tick = day_tick_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed, self-checking bench for time_set_ctrl with TICKS_PER_SEC = 4.
module tb_time_set_ctrl;

    localparam int unsigned TPS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       sec_tick;
    logic       blink;
    logic       day_tick;

    int checks = 0;
    int errors = 0;

    time_set_ctrl #(.TICKS_PER_SEC(TPS)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .hours   (hours),
        .minutes (minutes),
        .seconds (seconds),
        .mode    (mode),
        .sec_tick(sec_tick),
        .blink   (blink),
        .day_tick(day_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic bm;
        logic bi;
        int   md;
        int   hr;
        int   mn;
        int   sc;
        int   bl;
        int   st;
    } vec_t;

    localparam int NVEC = 37;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic bm, input logic bi, input int md, input int hr,
                                input int mn, input int sc, input int bl, input int st);
        vec_t v;
        v.bm = bm; v.bi = bi; v.md = md; v.hr = hr;
        v.mn = mn; v.sc = sc; v.bl = bl; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // From RUN with seconds at 0: set hours and minutes, then return to RUN.
    task automatic goto_time(input int h, input int m);
        press(1'b1, 1'b0);
        repeat (h) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (m) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
    endtask

    // Step until sec_tick is seen; a missing tick counts as a failure.
    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!sec_tick && n < 2 * TPS + 2);
        if (!sec_tick) chk({name, "_tick_timeout"}, 0, 1);
    endtask

    initial begin
        // Cycles 1..16 after reset release: free-running seconds.
        for (int i = 1; i <= 16; i++) begin
            vecs[i-1] = mk(1'b0, 1'b0, 0, 0, 0, i / 4, 0, (i % 4 == 0) ? 1 : 0);
        end
        vecs[16] = mk(1'b0, 1'b1, 0, 0, 0, 4, 0, 0);   // btn_inc ignored in RUN
        vecs[17] = mk(1'b1, 1'b0, 1, 0, 0, 0, 1, 0);   // enter SET_HR
        for (int r = 19; r <= 30; r++) begin
            vecs[r-1] = mk(1'b0, (r == 19 || r == 23) ? 1'b1 : 1'b0, 1, (r < 23) ? 1 : 2, 0, 0,
                           (((r - 18) / 4) % 2 == 0) ? 1 : 0, ((r - 18) % 4 == 0) ? 1 : 0);
        end
        vecs[30] = mk(1'b1, 1'b0, 2, 2, 0, 0, 1, 0);   // enter SET_MIN
        vecs[31] = mk(1'b0, 1'b1, 2, 2, 1, 0, 1, 0);
        vecs[32] = mk(1'b1, 1'b1, 0, 2, 1, 0, 0, 0);   // mode+inc: inc dropped
        vecs[33] = mk(1'b0, 1'b0, 0, 2, 1, 0, 0, 0);
        vecs[34] = mk(1'b0, 1'b0, 0, 2, 1, 0, 0, 0);
        vecs[35] = mk(1'b0, 1'b0, 0, 2, 1, 0, 0, 0);
        vecs[36] = mk(1'b0, 1'b0, 0, 2, 1, 1, 0, 1);   // first tick 4 cycles later

        rst      = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        #1;
        chk("rst_hours", hours, 0);
        chk("rst_minutes", minutes, 0);
        chk("rst_seconds", seconds, 0);
        chk("rst_mode", mode, 0);
        chk("rst_sec_tick", sec_tick, 0);
        chk("rst_blink", blink, 0);
        chk("rst_day_tick", day_tick, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < NVEC; r++) begin
            btn_mode = vecs[r].bm;
            btn_inc  = vecs[r].bi;
            step();
            btn_mode = 1'b0;
            btn_inc  = 1'b0;
            chk($sformatf("vec%0d_mode", r + 1), mode, vecs[r].md);
            chk($sformatf("vec%0d_hours", r + 1), hours, vecs[r].hr);
            chk($sformatf("vec%0d_minutes", r + 1), minutes, vecs[r].mn);
            chk($sformatf("vec%0d_seconds", r + 1), seconds, vecs[r].sc);
            chk($sformatf("vec%0d_blink", r + 1), blink, vecs[r].bl);
            chk($sformatf("vec%0d_sec_tick", r + 1), sec_tick, vecs[r].st);
            chk($sformatf("vec%0d_day_tick", r + 1), day_tick, 0);
        end

        // btn_mode on the same edge as a RUN tick: seconds cleared, not advanced.
        repeat (3) step();
        press(1'b1, 1'b0);
        chk("modetick_mode", mode, 1);
        chk("modetick_seconds", seconds, 0);

        // Reach SET_MIN with minutes=37, then reset between edges.
        press(1'b1, 1'b0);
        repeat (36) press(1'b0, 1'b1);
        chk("pre_async_mode", mode, 2);
        chk("pre_async_minutes", minutes, 37);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_hours", hours, 0);
        chk("async_minutes", minutes, 0);
        chk("async_seconds", seconds, 0);
        chk("async_mode", mode, 0);
        chk("async_blink", blink, 0);
        chk("async_sec_tick", sec_tick, 0);
        chk("async_day_tick", day_tick, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("post_rst_tick_c%0d", i), sec_tick, (i == 4) ? 1 : 0);
        end
        chk("post_rst_seconds", seconds, 1);

        // 10:20:30 -> set hours +15 and minutes +45, wrapping without carry.
        do_reset();
        goto_time(10, 20);
        repeat (30) wait_tick("run30");
        chk("t1_hours", hours, 10);
        chk("t1_minutes", minutes, 20);
        chk("t1_seconds", seconds, 30);
        press(1'b1, 1'b0);
        repeat (15) press(1'b0, 1'b1);
        chk("sethr_hours", hours, 1);
        chk("sethr_minutes", minutes, 20);
        chk("sethr_seconds", seconds, 0);
        chk("sethr_mode", mode, 1);
        press(1'b1, 1'b0);
        repeat (45) press(1'b0, 1'b1);
        chk("setmin_minutes", minutes, 5);
        chk("setmin_hours", hours, 1);
        chk("setmin_mode", mode, 2);

        // Midnight rollover.
        do_reset();
        goto_time(23, 59);
        repeat (58) wait_tick("run58");
        chk("t58_hours", hours, 23);
        chk("t58_minutes", minutes, 59);
        chk("t58_seconds", seconds, 58);
        wait_tick("t59");
        chk("t59_seconds", seconds, 59);
        chk("t59_day_tick", day_tick, 0);
        wait_tick("midnight");
        chk("mid_hours", hours, 0);
        chk("mid_minutes", minutes, 0);
        chk("mid_seconds", seconds, 0);
        chk("mid_day_tick", day_tick, 1);
        chk("mid_mode", mode, 0);
        step();
        chk("mid_day_tick_drop", day_tick, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 10000, meaning clk cycles per second (clk is 10 kHz, 100 us period).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port btn_mode, input, 1: debounced, clk-synchronous one-cycle pulse that advances the mode.
REQ-005 SHALL have port btn_inc, input, 1: debounced, clk-synchronous one-cycle pulse that increments the selected field.
REQ-006 SHALL have port hours, output, 5: hours 0..23.
REQ-007 SHALL have port minutes, output, 6: minutes 0..59.
REQ-008 SHALL have port seconds, output, 6: seconds 0..59.
REQ-009 SHALL have port mode, output, 2: 0=RUN, 1=SET_HR, 2=SET_MIN; value 3 never driven.
REQ-010 SHALL have port sec_tick, output, 1: one-cycle pulse once per second.
REQ-011 SHALL have port blink, output, 1: display-blink enable for the selected field.
REQ-012 SHALL have port day_tick, output, 1: one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Function
REQ-013 Prescaler SHALL count 0..TICKS_PER_SEC-1 and pulse sec_tick for one cycle when the count equals TICKS_PER_SEC-1, then wrap to 0; it runs in every mode.
REQ-014 FSM states SHALL be RUN, SET_HR and SET_MIN; btn_mode SHALL move RUN->SET_HR->SET_MIN->RUN; btn_mode SHALL be the only cause of a transition.
REQ-015 In RUN, each sec_tick SHALL increment seconds; seconds 59 SHALL wrap to 0 and carry to minutes; minutes 59 SHALL wrap to 0 and carry to hours; hours 23 SHALL wrap to 0.
REQ-016 day_tick SHALL assert in the same cycle in which 23:59:59 updates to 00:00:00, and only in RUN.
REQ-017 Entering SET_HR SHALL clear seconds to 0 and clear the prescaler count; seconds and prescaler count stay frozen at 0 through SET_HR and SET_MIN; sec_tick still pulses there.
REQ-018 In SET_HR, btn_inc SHALL increment hours modulo 24 with no carry; in SET_MIN, btn_inc SHALL increment minutes modulo 60 with no carry into hours.
REQ-019 btn_inc SHALL be ignored in RUN.
REQ-020 SET_MIN->RUN SHALL restart the prescaler from 0, so the first RUN sec_tick arrives exactly TICKS_PER_SEC cycles after the transition edge.
REQ-021 blink SHALL be 0 in RUN, SHALL load 1 on entry to SET_HR or SET_MIN, and SHALL toggle on each sec_tick while in a set state.
REQ-022 Simultaneous btn_mode and btn_inc SHALL apply btn_mode only; btn_inc is dropped.
REQ-023 Simultaneous btn_mode and sec_tick in RUN SHALL apply the transition; the tick is dropped and seconds is cleared per REQ-017.
REQ-024 All outputs SHALL be registered; a button pulse at edge N SHALL be visible on the outputs after edge N.

Reset
REQ-025 rst high SHALL immediately force hours=0, minutes=0, seconds=0, mode=RUN, prescaler=0, sec_tick=0, blink=0 and day_tick=0, independent of clk.
REQ-026 Reset asserted mid-operation in any state SHALL abort it; the first sec_tick after rst deasserts SHALL occur TICKS_PER_SEC cycles later.

Structure
REQ-027 A shared package SHALL hold the mode encodings (RUN=0, SET_HR=1, SET_MIN=2) and the constants MAX_HR=23 and MAX_MIN_SEC=59.
REQ-028 The prescaler SHALL be a sub-module named tick_prescaler with ports clk, rst, clr, tick and parameter TICKS_PER_SEC; FSM and counters stay in time_set_ctrl.

Verification (TICKS_PER_SEC=4)
REQ-029 Release rst, run 16 cycles -> sec_tick pulses at cycles 4, 8, 12, 16; seconds reads 4; mode=0; blink=0.
REQ-030 Preload 23:59:58 in RUN, wait 2 ticks -> 23:59:59, then 00:00:00 with day_tick high for exactly one cycle.
REQ-031 From 10:20:30 RUN: btn_mode, 15 btn_inc -> hours=1, seconds=0, mode=1; btn_mode, 45 btn_inc -> minutes=5, mode=2; no carry at either wrap.
REQ-032 In SET_MIN assert btn_mode and btn_inc in the same cycle -> mode=0, minutes unchanged; next sec_tick exactly 4 cycles after the transition.
REQ-033 In SET_HR over 3 sec_ticks -> blink 1,0,1,0; btn_inc in RUN -> no field change.
REQ-034 Assert rst asynchronously between clk edges in SET_MIN with minutes=37 -> all outputs 0 and mode=0 before the next clk edge.
